// File: rtl/ysyx_23060201_mem_resp_pkg.sv
// Shared definitions for the memory responder slice.
//   - word / byte-lane / counter widths
//   - default base address of word 0
//   - responder FSM state type
package ysyx_23060201_mem_resp_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MASK_W = WORD_W / BYTE_W;
    localparam int unsigned LAT_W  = 4;

    localparam logic [WORD_W-1:0] MEM_BASE_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_23060201_mem_resp_if.sv
// Request/response bus between the core (master) and the memory responder (slave).
//   req_valid/req_ready : request handshake, master -> slave
//   req_wen             : 1 = write, 0 = read
//   req_addr            : byte address (bits [1:0] ignored)
//   req_wdata/req_wmask : write data and byte enables
//   rsp_valid/rsp_ready : response handshake, slave -> master
//   rsp_rdata/rsp_err   : read data (0 for writes/errors), out-of-range flag
interface ysyx_23060201_mem_resp_if;
    import ysyx_23060201_mem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_23060201_mem_resp_array.sv
// DEPTH x 32 single-port word array with byte write enables and a registered read.
//   clk_i/rst_i : clock, async active-high reset (read register only; contents are not reset)
//   rd_en_i     : load rdata_o from the addressed word
//   wr_en_i     : update the byte lanes selected by wmask_i
//   clr_i       : load rdata_o with zero (writes and rejected accesses)
//   addr_i      : word index
//   rdata_o     : registered read data, held until the next access
module ysyx_23060201_mem_array
    import ysyx_23060201_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_en_i,
    input  logic                     wr_en_i,
    input  logic                     clr_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    input  logic [MASK_W-1:0]        wmask_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int unsigned i = 0; i < MASK_W; i++) begin
                if (wmask_i[i]) begin
                    mem_q[addr_i][BYTE_W*i +: BYTE_W] <= wdata_i[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_23060201_mem_resp.sv
// Memory responder: word-organised SRAM behind a valid/ready request channel and a
// valid/ready response channel, one outstanding transaction, LATENCY wait cycles
// between request accept and the array access.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : slave side of the request/response bus
module ysyx_23060201_mem_resp
    import ysyx_23060201_mem_resp_pkg::*;
#(
    parameter int unsigned       DEPTH   = 4096,
    parameter logic [WORD_W-1:0] BASE    = MEM_BASE_DEFAULT,
    parameter int unsigned       LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_23060201_mem_resp_if.slave  bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [WORD_W:0] SPAN = (WORD_W+1)'(DEPTH) << 2;
    localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

    state_e            state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              wen_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic              req_fire;
    logic              access;
    logic              acc_wen;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [MASK_W-1:0] acc_wmask;
    logic [WORD_W:0]   offset;
    logic              in_range;
    logic [AW-1:0]     acc_idx;
    logic              rd_en;
    logic              wr_en;
    logic              clr;
    logic [WORD_W-1:0] rdata;

    always_comb begin
        req_fire = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;

        // With zero latency the access happens on the accept edge itself, so the
        // array is fed from the live request rather than the latched copy.
        if (state_q == ST_IDLE) begin
            acc_wen   = bus.req_wen;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wmask = bus.req_wmask;
        end else begin
            acc_wen   = wen_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wmask = wmask_q;
        end

        if (LATENCY == 0) begin
            access = req_fire;
        end else begin
            access = (state_q == ST_WAIT) && (cnt_q == LAT_W'(1));
        end

        // 33-bit subtraction: addresses below BASE wrap to huge values and fail the
        // compare, and BASE+4*DEPTH can never wrap past the top of the address space.
        offset   = {1'b0, acc_addr} - {1'b0, BASE};
        in_range = (offset < SPAN);
        acc_idx  = offset[AW+1:2];

        rd_en = access && in_range && !acc_wen;
        wr_en = access && in_range && acc_wen;
        clr   = access && !rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (access) begin
                rsp_err_q <= !in_range;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        wen_q       <= bus.req_wen;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wmask_q     <= bus.req_wmask;
                        cnt_q       <= LAT;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    ysyx_23060201_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i  (clk),
        .rst_i  (rst),
        .rd_en_i(rd_en),
        .wr_en_i(wr_en),
        .clr_i  (clr),
        .addr_i (acc_idx),
        .wdata_i(acc_wdata),
        .wmask_i(acc_wmask),
        .rdata_o(rdata)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_resp.sv
// Bench for the memory responder: a LATENCY=1 instance driven by a vector table,
// hand-written backpressure/reset sequences and a random phase against a byte-level
// memory model; a LATENCY=0 instance checks streaming throughput.
module tb_ysyx_23060201_mem_resp;
    import ysyx_23060201_mem_resp_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_23060201_mem_resp_if bus0 ();
    ysyx_23060201_mem_resp_if bus1 ();

    ysyx_23060201_mem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    ysyx_23060201_mem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    // known bytes of the memory image, keyed by byte offset from BASE
    logic [7:0] model [longint];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint x;
        longint b;
        x = longint'({32'h0, a});
        b = longint'({32'h0, BASE});
        return (x >= b) && (x < b + 4 * longint'(DEPTH));
    endfunction

    // One full transaction on dut0; rsp_ready is held low for 'hold' cycles once the
    // response appears. lat = cycles from the accept edge to rsp_valid (+1).
    task automatic txn0(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        bus0.req_wen   = wen;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_wmask = mask;
        bus0.req_valid = 1'b1;
        bus0.rsp_ready = (hold == 0);
        n = 0;
        while (!bus0.req_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        lat = 1;
        while (!bus0.rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rdata = bus0.rsp_rdata;
        err   = bus0.rsp_err;
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  m;
        logic        w;
        logic [31:0] exp_d;
        logic [31:0] km;
        longint      off;
        int          hold;
        int          r;

        bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_wmask = '0; bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.req_wmask = '0; bus1.rsp_ready = 1'b0;
        rst = 1'b1;

        // vectors applied in order on dut0 (LATENCY=1)
        vecs.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0013, 32'h0,         4'h0,    32'hDE22_BE44, 1'b0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0,    32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hAAAA_5555, 4'hF,    32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF,    32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'h0,    32'hAAAA_5555, 1'b0});
        vecs.push_back('{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF,    32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_3FFC, 32'h0,         4'h0,    32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h8000_0020, 32'h0BAD_C0DE, 4'hF,    32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h8000_0020, 32'h1234_5678, 4'h0,    32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h8000_0020, 32'h0,         4'h0,    32'h0BAD_C0DE, 1'b0});

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready0", bus0.req_ready, 1);
        chk("rst_rsp_valid0", bus0.rsp_valid, 0);
        chk("rst_rdata0",     bus0.rsp_rdata, 0);
        chk("rst_err0",       bus0.rsp_err,   0);
        chk("rst_req_ready1", bus1.req_ready, 1);
        chk("rst_rsp_valid1", bus1.rsp_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- table
        foreach (vecs[i]) begin
            txn0(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 0, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i),   er, vecs[i].exp_err);
            chk($sformatf("vec%0d_lat", i),   lat, 2);
        end

        // ---------------- backpressure: response held 5 cycles, second request waits
        bus0.req_wen = 1'b0; bus0.req_addr = 32'h8000_0010; bus0.req_valid = 1'b1;
        bus0.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus0.req_addr = 32'h8000_0000;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", bus0.rsp_valid, 1);
            chk("bp_rdata",     bus0.rsp_rdata, 32'hDE22_BE44);
            chk("bp_req_ready", bus0.req_ready, 0);
            @(posedge clk); #1;
        end
        bus0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_rsp_valid", bus0.rsp_valid, 0);
        chk("bp_hs_req_ready", bus0.req_ready, 1);
        @(posedge clk); #1;
        chk("bp_second_accepted", bus0.req_ready, 0);
        bus0.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_second_valid", bus0.rsp_valid, 1);
        chk("bp_second_rdata", bus0.rsp_rdata, 32'hAAAA_5555);
        @(posedge clk); #1;

        // ---------------- reset mid-WAIT abandons a pending write
        txn0(1'b1, 32'h8000_0040, 32'h1111_1111, 4'hF, 0, rd, er, lat);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) txn0(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, rd, er, lat);
            else        txn0(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat);
            bus0.req_wen = 1'b1; bus0.req_addr = 32'h8000_0040;
            bus0.req_wdata = (k == 0) ? 32'h2222_2222 : 32'h3333_3333;
            bus0.req_wmask = 4'hF; bus0.req_valid = 1'b1;
            @(posedge clk); #1;
            chk("mid_wait_req_ready", bus0.req_ready, 0);
            if (k == 0) chk("pre_rst_rdata", bus0.rsp_rdata, 32'h1111_1111);
            else        chk("pre_rst_err",   bus0.rsp_err,   1);
            rst = 1'b1;
            #1;
            chk("arst_req_ready", bus0.req_ready, 1);
            chk("arst_rsp_valid", bus0.rsp_valid, 0);
            chk("arst_rdata",     bus0.rsp_rdata, 0);
            chk("arst_err",       bus0.rsp_err,   0);
            bus0.req_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            txn0(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, rd, er, lat);
            chk("abandoned_write", rd, 32'h1111_1111);
        end

        // ---------------- random phase against the byte model
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            else if (r == 7) a = BASE - 32'(4 * $urandom_range(1, 8));
            else if (r == 8) a = BASE + 32'(4 * DEPTH) - 32'h4 + 32'(4 * $urandom_range(0, 2));
            else             a = $urandom;
            w    = 1'($urandom_range(0, 1));
            wd   = $urandom;
            m    = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            txn0(w, a, wd, m, hold, rd, er, lat);
            chk("rnd_lat", lat, 2);
            chk("rnd_err", er, !in_rng(a));
            off = longint'({32'h0, a & 32'hFFFF_FFFC}) - longint'({32'h0, BASE});
            if (w || !in_rng(a)) begin
                chk("rnd_rdata_zero", rd, 0);
                if (w && in_rng(a)) begin
                    for (int b = 0; b < 4; b++)
                        if (m[b]) model[off + b] = wd[8*b +: 8];
                end
            end else begin
                exp_d = '0;
                km    = '0;
                for (int b = 0; b < 4; b++) begin
                    if (model.exists(off + b)) begin
                        exp_d[8*b +: 8] = model[off + b];
                        km[8*b +: 8]    = 8'hFF;
                    end
                end
                chk("rnd_read", rd & km, exp_d);
            end
        end

        // ---------------- LATENCY=0 streaming on dut1
        bus1.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus1.req_wen = 1'b1; bus1.req_addr = BASE + 32'(4 * i);
            bus1.req_wdata = 32'hA500_0000 + 32'(i); bus1.req_wmask = 4'hF;
            bus1.req_valid = 1'b1;
            chk("l0_wr_ready", bus1.req_ready, 1);
            @(posedge clk); #1;
            bus1.req_valid = 1'b0;
            chk("l0_wr_valid", bus1.rsp_valid, 1);
            @(posedge clk); #1;
        end
        bus1.req_wen = 1'b0; bus1.req_addr = BASE; bus1.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("l0_rd_ready", bus1.req_ready, 1);
            @(posedge clk); #1;
            chk("l0_rd_valid", bus1.rsp_valid, 1);
            chk("l0_rd_busy",  bus1.req_ready, 0);
            chk("l0_rd_data",  bus1.rsp_rdata, 32'hA500_0000 + 32'(i));
            bus1.req_addr = BASE + 32'(4 * (i + 1));
            @(posedge clk); #1;
        end
        bus1.req_valid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
